// File: rtl/serial_comparator_32bit.sv
// Multi-cycle magnitude comparator: scans operands one DIGIT-bit digit per
// cycle, most-significant digit first, stopping at the first unequal digit.
// Supports signed (two's-complement) and unsigned compares with a
// start/done handshake and registered gt/lt/eq flags.
module serial_comparator_32bit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             signed_reg, signed_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             gt_reg, gt_next;
  logic             lt_reg, lt_next;
  logic             eq_reg, eq_next;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             first_dig;
  logic             sign_split;

  // Current digit of each latched operand and the signed early-out condition
  assign a_dig      = a_reg[idx_reg*DIGIT +: DIGIT];
  assign b_dig      = b_reg[idx_reg*DIGIT +: DIGIT];
  assign first_dig  = (idx_reg == LAST_IDX);
  assign sign_split = signed_reg && first_dig && (a_reg[WIDTH-1] != b_reg[WIDTH-1]);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      idx_reg    <= LAST_IDX;
      gt_reg     <= 1'b0;
      lt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      idx_reg    <= idx_next;
      gt_reg     <= gt_next;
      lt_reg     <= lt_next;
      eq_reg     <= eq_next;
    end
  end

  // Next-state logic: latch on start, scan digits, decide, pulse done
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    idx_next    = idx_reg;
    gt_next     = gt_reg;
    lt_next     = lt_reg;
    eq_next     = eq_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next      = a;
          b_next      = b;
          signed_next = is_signed;
          idx_next    = LAST_IDX;
          state_next  = SCAN;
        end
      end
      SCAN: begin
        if (sign_split) begin
          // Negative operand is the smaller one regardless of magnitude bits
          lt_next    = a_reg[WIDTH-1];
          gt_next    = ~a_reg[WIDTH-1];
          eq_next    = 1'b0;
          state_next = DONE;
        end else if (a_dig != b_dig) begin
          gt_next    = (a_dig > b_dig);
          lt_next    = (a_dig < b_dig);
          eq_next    = 1'b0;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          gt_next    = 1'b0;
          lt_next    = 1'b0;
          eq_next    = 1'b1;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign gt   = gt_reg;
  assign lt   = lt_reg;
  assign eq   = eq_reg;

endmodule

// File: tb/tb_serial_comparator_32bit.sv
// Self-checking bench for serial_comparator_32bit: expected results are
// queued when a compare is launched and popped when done is observed.
module tb_serial_comparator_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic        gt;
  logic        lt;
  logic        eq;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   k;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   done_cnt;
  logic prev_gt, prev_lt, prev_eq;

  serial_comparator_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every done pulse seen mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  // Launch one compare, wait for done, check flags, latency and pulse width
  task automatic do_cmp(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic egt, input logic elt,
                        input logic eeq, input int ek);
    exp_t e;
    int   n;
    e.gt = egt; e.lt = elt; e.eq = eeq; e.k = ek;
    exp_q.push_back(e);
    @(negedge clk);
    a = av; b = bv; is_signed = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = ~sv;
    n = 1;
    total++;
    if (busy !== 1'b1 || {gt, lt, eq} !== {prev_gt, prev_lt, prev_eq}) begin
      bad++;
      $display("FAIL %s first_cycle: busy=%b flags=%b%b%b required busy=1 flags=%b%b%b",
               name, busy, gt, lt, eq, prev_gt, prev_lt, prev_eq);
    end
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: done never seen, required latency %0d", name, e.k);
    end else begin
      $display("%s: gt=%b lt=%b eq=%b latency=%0d", name, gt, lt, eq, n - 1);
      if ({gt, lt, eq} !== {e.gt, e.lt, e.eq} || (n - 1) != e.k || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s result: gt/lt/eq=%b%b%b k=%0d busy=%b required %b%b%b k=%0d busy=1",
                 name, gt, lt, eq, n - 1, busy, e.gt, e.lt, e.eq, e.k);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || {gt, lt, eq} !== {e.gt, e.lt, e.eq}) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b flags=%b%b%b required 0 0 %b%b%b",
               name, done, busy, gt, lt, eq, e.gt, e.lt, e.eq);
    end
    prev_gt = e.gt; prev_lt = e.lt; prev_eq = e.eq;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: busy/done/gt/lt/eq=%b required 00000", {busy, done, gt, lt, eq});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("FAIL reset_release: busy/done/gt/lt/eq=%b required 00000", {busy, done, gt, lt, eq});
    end
    $display("reset: outputs=%b", {busy, done, gt, lt, eq});
    prev_gt = 1'b0; prev_lt = 1'b0; prev_eq = 1'b0;
  endtask

  task automatic test_msb_decide();
    do_cmp("msb_unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 0, 0, 1);
    do_cmp("msb_signed",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 1, 0, 1);
    do_cmp("ff_vs_1_uns",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 0, 0, 1);
    do_cmp("ff_vs_1_sgn",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1, 0, 1);
  endtask

  task automatic test_full_scan();
    do_cmp("eq_unsigned",  32'h1234_5678, 32'h1234_5678, 1'b0, 0, 0, 1, 8);
    do_cmp("eq_signed",    32'h1234_5678, 32'h1234_5678, 1'b1, 0, 0, 1, 8);
    do_cmp("low_digit",    32'h0000_0005, 32'h0000_0003, 1'b0, 1, 0, 0, 8);
    do_cmp("neg_low",      32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1, 0, 0, 8);
    do_cmp("mid_digit",    32'h0010_0000, 32'h0020_0000, 1'b0, 0, 1, 0, 3);
    do_cmp("neg_mid",      32'h8100_0000, 32'h8200_0000, 1'b1, 0, 1, 0, 2);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   d0;
    e.gt = 1'b1; e.lt = 1'b0; e.eq = 1'b0; e.k = 1;
    exp_q.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    a = 32'h1000_0000; b = 32'h0FFF_FFFF; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'h0; b = 32'h1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_scan: busy=%b required 1", busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL busy_done_cycle: done=%b required 1", done);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    $display("busy_protect: dones=%0d flags=%b%b%b", done_cnt - d0, gt, lt, eq);
    if ((done_cnt - d0) != 1 || {gt, lt, eq} !== {e.gt, e.lt, e.eq} || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_protect: dones=%0d flags=%b%b%b busy=%b required 1 %b%b%b 0",
               done_cnt - d0, gt, lt, eq, busy, e.gt, e.lt, e.eq);
    end
    prev_gt = e.gt; prev_lt = e.lt; prev_eq = e.eq;
    do_cmp("after_busy", 32'h0, 32'h1, 1'b0, 0, 1, 0, 8);
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: busy/done/gt/lt/eq=%b required 00000", {busy, done, gt, lt, eq});
    end
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    $display("reset_mid: dones_after=%0d outputs=%b", done_cnt - d0, {busy, done, gt, lt, eq});
    if ((done_cnt - d0) != 0 || {busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("FAIL reset_abort: dones=%0d outputs=%b required 0 00000",
               done_cnt - d0, {busy, done, gt, lt, eq});
    end
    prev_gt = 1'b0; prev_lt = 1'b0; prev_eq = 1'b0;
    do_cmp("post_reset", 32'd2, 32'd7, 1'b0, 0, 1, 0, 8);
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0;
    start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    prev_gt = 1'b0; prev_lt = 1'b0; prev_eq = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_msb_decide();
    test_full_scan();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
